// File: rtl/dtlb_miss_walker.sv
// Store-side DTLB miss sequencer: dedup miss queue, one page walk at a time,
// TLB write then mex replay under bus_hold.
// Ports: clk/rst/except, miss_* (AGU miss in), req_*/resp_* (walker side),
// writeTlb_* and mex_*/bus_hold (to AGU), walk_fault* (fault report).
`ifndef dtlbData_width
`define dtlbData_width 64
`endif

module dtlb_miss_walker #(
  parameter int DEPTH   = 4,
  parameter int DATA_W  = `dtlbData_width,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              except,
  input  logic              miss_en,
  input  logic [43:0]       miss_addr,
  input  logic [20:0]       miss_proc,
  input  logic [3:0]        miss_attr,
  output logic              miss_drop,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [51:0]       req_tag,
  input  logic              resp_valid,
  input  logic              resp_fault,
  input  logic [DATA_W-1:0] resp_data0,
  input  logic [DATA_W-1:0] resp_data1,
  input  logic [DATA_W-1:0] resp_data2,
  output logic [50:0]       writeTlb_IP,
  output logic              writeTlb_wen,
  output logic [DATA_W-1:0] writeTlb_data0,
  output logic [DATA_W-1:0] writeTlb_data1,
  output logic [DATA_W-1:0] writeTlb_data2,
  output logic [2:0]        writeTlb_force_way,
  output logic              writeTlb_force_way_en,
  output logic              mex_en,
  output logic [43:0]       mex_addr,
  output logic [3:0]        mex_attr,
  output logic              bus_hold,
  output logic              walk_fault,
  output logic [43:0]       walk_fault_addr
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    WAIT   = 3'd2,
    WRITE  = 3'd3,
    REPLAY = 3'd4,
    FAULT  = 3'd5,
    DRAIN  = 3'd6
  } state_t;

  state_t state_q, state_d;

  logic [DEPTH-1:0]  q_valid;
  logic [51:0]       q_tag  [DEPTH];
  logic [43:0]       q_addr [DEPTH];
  logic [3:0]        q_attr [DEPTH];
  logic [AW-1:0]     head_q, tail_q;
  logic [AW:0]       count_q;
  logic [7:0]        cnt_q;
  logic [DATA_W-1:0] d0_q, d1_q, d2_q;
  logic              drop_q;

  logic [51:0] miss_tag;
  logic        hit, pop, full, push, drop, timed_out;

  assign miss_tag = {miss_proc, miss_addr[43:13]};

  // Match covers every live entry, including the head being walked.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (q_valid[i] && q_tag[i] == miss_tag) hit = 1'b1;
    end
  end

  assign pop       = (state_q == REPLAY) || (state_q == FAULT);
  assign full      = count_q == (AW+1)'(DEPTH);
  // A pop in the same cycle frees the slot a full queue needs.
  assign push      = miss_en & ~except & ~hit & (~full | pop);
  assign drop      = miss_en & ~except & ~hit & full & ~pop;
  assign timed_out = cnt_q == 8'(TIMEOUT);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (!except && count_q != '0) state_d = REQ;
      REQ: begin
        if (except)         state_d = IDLE;
        else if (req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (except)          state_d = resp_valid ? IDLE : DRAIN;
        else if (resp_valid) state_d = resp_fault ? FAULT : WRITE;
        else if (timed_out)  state_d = FAULT;
      end
      WRITE:  state_d = except ? IDLE : REPLAY;
      REPLAY: state_d = IDLE;
      FAULT:  state_d = IDLE;
      DRAIN:  if (resp_valid || timed_out) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      drop_q  <= 1'b0;
      d0_q    <= '0;
      d1_q    <= '0;
      d2_q    <= '0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop;
      // Counter restarts on every state change, so WAIT and DRAIN
      // each get a full timeout window.
      if (state_d != state_q)
        cnt_q <= '0;
      else if (state_q == WAIT || state_q == DRAIN)
        cnt_q <= cnt_q + 8'd1;
      else
        cnt_q <= '0;
      if (state_q == WAIT && resp_valid && !resp_fault) begin
        d0_q <= resp_data0;
        d1_q <= resp_data1;
        d2_q <= resp_data2;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_valid <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_tag[i]  <= '0;
        q_addr[i] <= '0;
        q_attr[i] <= '0;
      end
    end else if (except) begin
      q_valid <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (pop) begin
        q_valid[head_q] <= 1'b0;
        head_q          <= head_q + 1'b1;
      end
      // Ordered after pop: on a full queue tail == head and the
      // new entry must win the valid bit.
      if (push) begin
        q_valid[tail_q] <= 1'b1;
        q_tag[tail_q]   <= miss_tag;
        q_addr[tail_q]  <= miss_addr;
        q_attr[tail_q]  <= miss_attr;
        tail_q          <= tail_q + 1'b1;
      end
      count_q <= count_q + {{AW{1'b0}}, push}
                         - {{AW{1'b0}}, pop};
    end
  end

  assign miss_drop             = drop_q;
  assign req_valid             = state_q == REQ;
  assign req_tag               = q_tag[head_q];
  assign writeTlb_wen          = state_q == WRITE;
  assign writeTlb_IP           = q_tag[head_q][51:1];
  assign writeTlb_data0        = d0_q;
  assign writeTlb_data1        = d1_q;
  assign writeTlb_data2        = d2_q;
  assign writeTlb_force_way    = 3'd0;
  assign writeTlb_force_way_en = 1'b0;
  assign mex_en                = state_q == REPLAY;
  assign mex_addr              = q_addr[head_q];
  assign mex_attr              = q_attr[head_q];
  assign bus_hold              = (state_q == WRITE) || (state_q == REPLAY);
  assign walk_fault            = state_q == FAULT;
  assign walk_fault_addr       = q_addr[head_q];

endmodule

// File: doc/dtlb_miss_walker.md
# dtlb_miss_walker

Store-side DTLB miss sequencer, directly downstream of the store AGU's `tlbMiss` output and upstream of its `mex_*` / `writeTlb_*` inputs.
- Captures missing translations into a small deduplicating queue and issues one page-walk request at a time to the memory side.
- Writes the returned entry into the AGU's DTLB, then replays the address through the AGU's `mex` port while holding off normal issue with `bus_hold`.

## Interface
Parameters:
- DEPTH, 4: miss queue entries (power of 2).
- DATA_W, `dtlbData_width: TLB data word width.
- TIMEOUT, 255: WAIT cycles before a walk is declared faulted (8-bit counter).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- except  in  1  pipeline flush.
- miss_en  in  1  AGU reports a TLB miss this cycle.
- miss_addr  in  44  virtual address of the missing op.
- miss_proc  in  21  process id (`proc[20:0]`).
- miss_attr  in  4  attributes of the missing op.
- miss_drop  out  1  pulse: miss discarded because the queue is full.
- req_valid  out  1  page-walk request valid.
- req_ready  in  1  walker accepts request.
- req_tag  out  52  `{proc[20:0], vaddr[43:13]}`.
- resp_valid  in  1  walk response, single cycle.
- resp_fault  in  1  walk found no valid mapping.
- resp_data0/1/2  in  DATA_W  TLB way data.
- writeTlb_IP  out  51  `tag[51:1]`.
- writeTlb_wen  out  1  TLB write strobe.
- writeTlb_data0/1/2  out  DATA_W  TLB write data.
- writeTlb_force_way  out  3  constant 0.
- writeTlb_force_way_en  out  1  constant 0.
- mex_en  out  1  replay strobe to the AGU.
- mex_addr  out  44  replay address.
- mex_attr  out  4  replay attributes.
- bus_hold  out  1  suppresses AGU normal output.
- walk_fault  out  1  pulse: walk faulted or timed out.
- walk_fault_addr  out  44  address of the faulted walk.

## Operation
- Queue: FIFO of DEPTH entries holding `{valid, tag, addr, attr}`, plus a log2(DEPTH)+1 bit count.
- Push on miss_en unless one of these holds:
  - The tag matches any valid entry; the in-flight head is included. The miss is silently merged.
  - The queue is full and there is no tag match. `miss_drop` pulses and the miss is discarded.
- Pop happens only from the REPLAY or FAULT state. Push and pop in the same cycle are both honoured and the count is unchanged.
- FSM states: IDLE, REQ, WAIT, WRITE, REPLAY, FAULT, DRAIN.
  - IDLE -> REQ when the queue is non-empty.
  - REQ: `req_valid`=1 with the head tag. Go to WAIT on `req_valid & req_ready`.
  - WAIT: the timeout counter starts from 0 on entry.
    - On `resp_valid & ~resp_fault`: register the data and go to WRITE.
    - On `resp_valid & resp_fault`, or when the counter reaches TIMEOUT: go to FAULT.
  - WRITE: `writeTlb_wen`=1 and `bus_hold`=1, then go to REPLAY.
  - REPLAY: `mex_en`=1 and `bus_hold`=1, with `mex_addr`/`mex_attr` taken from the head. Pop, then go to IDLE.
  - FAULT: `walk_fault`=1 with `walk_fault_addr`=head addr. Pop, then go to IDLE.
  - DRAIN: wait for `resp_valid` or timeout, discard the response, then go to IDLE. No TLB write occurs.
- `except`: all queue entries are invalidated and count←0 in that cycle. A simultaneous miss_en is ignored. The state moves as follows:
  - REQ: go to IDLE; withdrawing `req_valid` is permitted only on except.
  - WAIT: go to DRAIN.
  - WRITE: the write completes, then go to IDLE with no replay.
  - REPLAY or FAULT: the current-cycle pulse completes, then go to IDLE.
- `req_valid` is stable, with a stable tag, until accepted unless except occurs.
- Reset: all outputs 0, queue empty, state IDLE, counter 0. Reset overrides except and miss_en.

## Timing
- Miss at cycle N: the entry is visible at N+1, and REQ with `req_valid` starts at N+2 when the block was idle.
- Handshake at cycle R: the earliest response is R+1.
- Response at cycle W: WRITE at W+1, REPLAY/`mex_en` at W+2, IDLE at W+3, next REQ at W+4.
- `bus_hold` is high for exactly 2 cycles per successful walk, covering WRITE and REPLAY.
- Timeout: FAULT is entered on the cycle after the counter hits TIMEOUT, i.e. 256 cycles after entering WAIT.
- All outputs are registered or decoded from state.
- `writeTlb_*` and `mex_*` never assert in the same cycle.

## Test plan
- Single miss: `miss_addr`=0x0000_1234_5678, proc=5, `req_ready`=1, response 3 cycles later with data0=0xA5.
  - Expect `req_tag`={21'd5, 31'h91A2}.
  - Expect `writeTlb_wen` with IP=`req_tag[51:1]` and data0=0xA5.
  - Expect `mex_en` next cycle with the same addr, and `bus_hold` high for 2 cycles.
- Dedup/full: 6 misses on 5 distinct pages plus one repeat while `req_ready`=0.
  - The repeat is merged.
  - The 5th distinct page gets `miss_drop`=1.
  - Exactly 4 walks are issued, in FIFO order.
- Fault: `resp_fault`=1.
  - Expect `walk_fault` for 1 cycle with the correct addr.
  - Expect no `writeTlb_wen` and no `mex_en`; the queue count is decremented.
- Timeout: no response after the handshake.
  - Expect `walk_fault` 256 cycles after WAIT entry, then the next queued walk issues.
- Except in WAIT with 3 entries queued.
  - Expect the queue to empty and the state to be DRAIN.
  - Then `resp_valid` arrives: expect no TLB write and no replay, and the state returns to IDLE.
- Push and pop in the same cycle at REPLAY with a full queue.
  - Expect the new miss to be accepted, with no `miss_drop` and count unchanged.
